// File: rtl/srt_quot_post.sv
// srt_quot_post
//   Post-processing stage behind the radix-4 SRT iteration core.
//   Converts the signed quotient digit stream to binary on the fly (QP/QM
//   pair), then corrects the final partial remainder for sign/overshoot,
//   denormalizes the remainder and presents Q/R with a one-cycle DONE.
//
// Ports
//   CLK         rising-edge clock
//   RST_N       synchronous active-low reset
//   START       begin a division (accepted in IDLE only)
//   SHIFT[5:0]  normalization shift count, captured with START
//   DIG_VALID   DIG carries a quotient digit this cycle
//   DIG[2:0]    signed digit, legal -2..+2
//   PREM_VALID  PREM/DSR_NORM valid this cycle
//   PREM[W:0]   signed final partial remainder (normalized scale)
//   DSR_NORM    normalized divisor
//   Q, R        final quotient / denormalized remainder
//   BUSY        high in every state except IDLE
//   DONE        one-cycle completion pulse
//   ERR         sticky illegal-digit flag, cleared on accepted START
module srt_quot_post #(
  parameter int W    = 64,
  parameter int NDIG = W / 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [5:0]   SHIFT,
  input  logic         DIG_VALID,
  input  logic [2:0]   DIG,
  input  logic         PREM_VALID,
  input  logic [W:0]   PREM,
  input  logic [W-1:0] DSR_NORM,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_REM,
    CORR,
    FIN
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [5:0]     shift_r;
  logic [W-1:0]   qp, qm, qf;
  logic [W:0]     prem_r, rc;
  logic [W-1:0]   dsr_r;

  logic           dig_illegal;
  logic [2:0]     d;
  logic           d_neg, d_pos;
  logic [1:0]     qp_lsb, qm_lsb;
  logic           last_dig;
  logic [W:0]     dsr_ext;

  // Digit decode. Only the low two bits of each appended digit matter, so the
  // (4+d), (d-1) and (3+d) terms reduce to 2-bit modular arithmetic on d[1:0].
  always_comb begin
    dig_illegal = (DIG == 3'b011) || (DIG == 3'b100) || (DIG == 3'b101);
    d           = dig_illegal ? 3'b000 : DIG;
    d_neg       = d[2];
    d_pos       = !d[2] && (d != 3'b000);
    qp_lsb      = d[1:0];
    qm_lsb      = d_pos ? (d[1:0] - 2'd1) : (d[1:0] + 2'd3);
    last_dig    = (cnt == CW'(NDIG - 1));
    dsr_ext     = {1'b0, dsr_r};
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (START) state_nx = CONV;
      CONV:     if (DIG_VALID && last_dig) state_nx = WAIT_REM;
      WAIT_REM: if (PREM_VALID) state_nx = CORR;
      CORR:     state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt     <= '0;
      shift_r <= '0;
      qp      <= '0;
      qm      <= '0;
      qf      <= '0;
      prem_r  <= '0;
      dsr_r   <= '0;
      rc      <= '0;
      Q       <= '0;
      R       <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            qp      <= '0;
            qm      <= '0;
            cnt     <= '0;
            shift_r <= SHIFT;
            ERR     <= 1'b0;
          end
        end
        CONV: begin
          if (DIG_VALID) begin
            qp  <= d_neg ? {qm[W-3:0], qp_lsb} : {qp[W-3:0], qp_lsb};
            qm  <= d_pos ? {qp[W-3:0], qm_lsb} : {qm[W-3:0], qm_lsb};
            cnt <= cnt + 1'b1;
            if (dig_illegal) ERR <= 1'b1;
          end
        end
        WAIT_REM: begin
          if (PREM_VALID) begin
            prem_r <= PREM;
            dsr_r  <= DSR_NORM;
          end
        end
        CORR: begin
          // Unsigned compare is valid here because the sign bit is clear.
          if (prem_r[W]) begin
            rc <= prem_r + dsr_ext;
            qf <= qm;
          end else if (prem_r >= dsr_ext) begin
            rc <= prem_r - dsr_ext;
            qf <= qp + 1'b1;
          end else begin
            rc <= prem_r;
            qf <= qp;
          end
        end
        FIN: begin
          // rc[W] is zero after correction, so shifting the full W+1 bits and
          // truncating equals shifting rc[W-1:0].
          Q    <= qf;
          R    <= W'(rc >> shift_r);
          DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
